// File: rtl/add64_if.sv
// Operand/result bundle of the 64-bit sequential adder, including the
// side channel to the shared 32-bit adder it borrows for two cycles per add.
interface add64_if;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        c_in;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        c_out;
  logic        ovf;

  // start is a one-cycle request, honoured only in IDLE or DONE; done is a
  // one-cycle pulse marking sum/c_out/ovf valid, and busy covers LO and HI.
  modport slave (
    input  start, A, B, c_in, add_sum, add_cout,
    output add_a, add_b, add_cin, busy, done, sum, c_out, ovf
  );

  modport master (
    output start, A, B, c_in, add_sum, add_cout,
    input  add_a, add_b, add_cin, busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/add64_seq_ctrl.sv
// 64-bit adder built from two passes through a shared 32-bit adder:
// low half in LO, high half in HI, result presented with a done pulse.
module add64_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  add64_if.slave      bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        load;
  logic [63:0] a_q, b_q;
  logic        cin_q;
  logic        carry_q;
  logic [63:0] sum_q;
  logic        c_out_q;
  logic        ovf_q;
  logic        ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= bus.A;
        b_q   <= bus.B;
        cin_q <= bus.c_in;
      end
      if (state_q == LO) begin
        sum_q[31:0] <= bus.add_sum;
        carry_q     <= bus.add_cout;
      end
      if (state_q == HI) begin
        sum_q[63:32] <= bus.add_sum;
        c_out_q      <= bus.add_cout;
        ovf_q        <= ovf_d;
      end
    end
  end

  // Overflow uses the captured operands and the high-half sum bit 63.
  assign ovf_d = (a_q[63] == b_q[63]) && (bus.add_sum[31] != a_q[63]);

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        bus.add_a   = a_q[31:0];
        bus.add_b   = b_q[31:0];
        bus.add_cin = cin_q;
        state_d     = HI;
      end
      HI: begin
        bus.add_a   = a_q[63:32];
        bus.add_b   = b_q[63:32];
        bus.add_cin = carry_q;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == LO) || (state_q == HI);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Bench for add64_seq_ctrl: reference 32-bit adder, per-phase checks and a
// result scoreboard keyed on the done pulse.
module tb_add64_seq_ctrl;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add64_if    bus ();
  logic [1:0] state_dbg;

  add64_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Shared combinational 32-bit adder the block borrows.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

  int          total = 0;
  int          bad   = 0;
  logic [65:0] exp_q[$];
  logic [65:0] last_e = '0;
  logic [65:0] mon_e;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {ovf, c_out, sum}.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [64:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    ov   = (a[63] == b[63]) && (full[63] != a[63]);
    return {ov, full[64], full[63:0]};
  endfunction

  // ---- scoreboard ----
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {bus.ovf, bus.c_out, bus.sum}, mon_e);
      end
    end
  end

  // ---- driver tasks ----
  // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE negedge.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input bit hold_start);
    logic [65:0] e;
    logic [32:0] lo;
    e  = model(a, b, cin);
    lo = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, cin};
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.c_in  = cin;
    exp_q.push_back(e);
    @(negedge clk);
    // Scramble inputs while busy: the captured operands must not move.
    bus.start = hold_start;
    bus.A     = {$urandom, $urandom};
    bus.B     = {$urandom, $urandom};
    bus.c_in  = 1'($urandom_range(0, 1));
    check("lo_state", state_dbg, 2'd1);
    check("lo_busy", bus.busy, 1);
    check("lo_done", bus.done, 0);
    check("lo_add_a", bus.add_a, a[31:0]);
    check("lo_add_b", bus.add_b, b[31:0]);
    check("lo_add_cin", bus.add_cin, cin);
    @(negedge clk);
    check("hi_state", state_dbg, 2'd2);
    check("hi_busy", bus.busy, 1);
    check("hi_done", bus.done, 0);
    check("hi_add_a", bus.add_a, a[63:32]);
    check("hi_add_b", bus.add_b, b[63:32]);
    check("hi_add_cin", bus.add_cin, lo[32]);
    check("hi_sum_lo", bus.sum[31:0], e[31:0]);
    @(negedge clk);
    check("done_state", state_dbg, 2'd3);
    check("done_busy", bus.busy, 0);
    check("done_pulse", bus.done, 1);
    check("done_add_a", bus.add_a, 0);
    check("done_add_b", bus.add_b, 0);
    check("done_add_cin", bus.add_cin, 0);
    last_e = e;
  endtask

  task automatic idle_check();
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_state", state_dbg, 2'd0);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_add_a", bus.add_a, 0);
    check("idle_add_b", bus.add_b, 0);
    check("idle_add_cin", bus.add_cin, 0);
    check("idle_hold", {bus.ovf, bus.c_out, bus.sum}, last_e);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_state"}, state_dbg, 2'd0);
    check({tag, "_result"}, {bus.ovf, bus.c_out, bus.sum}, 66'd0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_add"}, {bus.add_a, bus.add_b, bus.add_cin}, 65'd0);
  endtask

  // ---- stimulus ----
  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.c_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_values("rst");
    rst_n = 1'b1;

    // Scenario A, started at the first edge after reset release.
    do_op(64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0);
    idle_check();
    // Scenario B.
    do_op(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0);
    idle_check();
    // Scenario C.
    do_op(64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0);
    idle_check();
    do_op(64'h80000000_00000000, 64'h80000000_00000000, 1'b0, 1'b0);
    idle_check();

    // Scenario D: start held high, a new pair presented in each DONE cycle.
    for (int i = 0; i < 3; i++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    end
    idle_check();

    for (int i = 0; i < 4; i++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      if (i[0]) idle_check();
    end
    idle_check();

    // Scenario E: reset during HI aborts without a done pulse.
    bus.start = 1'b1;
    bus.A     = 64'hDEADBEEF_12345678;
    bus.B     = 64'h0F0F0F0F_F0F0F0F0;
    bus.c_in  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("e_in_hi", state_dbg, 2'd2);
    #1 rst_n = 1'b0;
    #1 reset_values("e_async");
    @(negedge clk);
    reset_values("e_held");
    rst_n  = 1'b1;
    last_e = '0;
    do_op(64'd5, 64'd7, 1'b0, 1'b0);
    check("e_sum12", bus.sum, 64'd12);
    idle_check();
    idle_check();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add64_seq_ctrl.md
ADD64_SEQ_CTRL -- requirements
Module: add64_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 A  input  64  operand A; captured on an accepted start.
REQ-006 B  input  64  operand B; captured on an accepted start.
REQ-007 c_in  input  1  carry-in; captured on an accepted start.
REQ-008 add_a  output  32  operand A half, driven to the shared 32-bit adder.
REQ-009 add_b  output  32  operand B half, driven to the shared 32-bit adder.
REQ-010 add_cin  output  1  carry-in, driven to the shared 32-bit adder.
REQ-011 add_sum  input  32  sum returned by the shared adder; combinational, same cycle.
REQ-012 add_cout  input  1  carry-out returned by the shared adder.
REQ-013 busy  output  1  high while in LO or HI.
REQ-014 done  output  1  single-cycle pulse; result valid.
REQ-015 sum  output  64  registered 64-bit result.
REQ-016 c_out  output  1  registered carry-out of bit 63.
REQ-017 ovf  output  1  registered signed overflow: (A[63]==B[63]) && (sum[63]!=A[63]), using captured operands.

Function
REQ-018 States SHALL be IDLE, LO, HI and DONE, with a 2-bit encoding.
REQ-019 IDLE: start=1 SHALL capture A, B and c_in into operand registers and go to LO; start=0 SHALL stay in IDLE.
REQ-020 LO: the block SHALL drive add_a=Areg[31:0], add_b=Breg[31:0] and add_cin=cinreg.
REQ-021 LO: on the clock edge the block SHALL register add_sum into sum[31:0] and add_cout into the carry register, then go to HI.
REQ-022 HI: the block SHALL drive add_a=Areg[63:32], add_b=Breg[63:32] and add_cin=carry register.
REQ-023 HI: on the clock edge the block SHALL register add_sum into sum[63:32], add_cout into c_out and the computed ovf, then go to DONE.
REQ-024 DONE: done SHALL be 1 for exactly this cycle.
REQ-025 DONE: start=1 SHALL capture new operands and go to LO (back-to-back); start=0 SHALL go to IDLE.
REQ-026 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+2, i.e. 3 cycles per operation and 1 result every 3 cycles back-to-back.
REQ-027 start in LO or HI SHALL be ignored; operand registers SHALL NOT change while busy=1.
REQ-028 In IDLE and DONE, add_a, add_b and add_cin SHALL be driven to 0.
REQ-029 sum, c_out and ovf SHALL hold their last values from DONE until the next operation's LO/HI edges overwrite them.
REQ-030 sum[31:0] SHALL update at the LO edge, so during HI it already shows the new low half; consumers SHALL sample only when done=1.
REQ-031 All arithmetic SHALL be unsigned modulo 2^64; the carry SHALL chain only through the carry register, never combinationally from A/B.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE and busy=0, done=0, sum=0, c_out=0, ovf=0, the operand registers and carry register to 0, and add_a=0, add_b=0, add_cin=0.
REQ-033 Reset asserted mid-operation (LO or HI) SHALL abort the operation with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-034 start sampled at the first edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-035 Scenario A: A=0x00000000_FFFFFFFF, B=1, c_in=0 -> add_cin=1 in HI; sum=0x00000001_00000000, c_out=0, ovf=0, done at edge k+2.
REQ-036 Scenario B: A=B=0xFFFFFFFF_FFFFFFFF, c_in=1 -> sum=0xFFFFFFFF_FFFFFFFF, c_out=1, ovf=0.
REQ-037 Scenario C: A=0x7FFFFFFF_FFFFFFFF, B=1, c_in=0 -> sum=0x80000000_00000000, c_out=0, ovf=1.
REQ-038 Scenario D: start held high continuously with a new operand pair each DONE cycle -> done pulses every 3rd cycle; pulses at edges 2, 5, 8 after the first start; each result matches its own operands; start during LO/HI has no effect.
REQ-039 Scenario E: rst_n pulsed low during HI -> all outputs 0 immediately, no done pulse; a subsequent start with A=5, B=7 -> sum=12, c_out=0.
REQ-040 Scenario F: in IDLE and DONE, check add_a=add_b=0 and add_cin=0; busy=1 only in LO and HI.
